// File: rtl/core_output_buf_multi_pkg.sv
// Shared types and helpers for the multi-slot core output buffer.
// Optional feature macro: CORE_OUTPUT_BUF_ERR_CNT_EN (overwrite error counter).
package core_output_buf_multi_pkg;

    // Default geometry of the buffer.
    localparam int CORE_OUT_N_CTX   = 4;
    localparam int CORE_OUT_N_WORDS = 8;

    // Output state machine, one-hot encoded.
    typedef enum logic [3:0] {
        ST_NONE  = 4'b0001,
        ST_READY = 4'b0010,
        ST_START = 4'b0100,
        ST_READ  = 4'b1000
    } out_state_t;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/core_output_buf_multi_if.sv
// Bus bundle between core write-back, the output buffer and the unit output mux.
//
// Handshake: core_out_ready high means a result is offered on ctx_num/seq_num.
// The consumer accepts it by raising rd_en while ready is high; the offer is
// taken exactly once. Beats then follow on dout with dout_valid = 1, beat 0
// flagged by core_out_start; beats are contiguous and cannot be stalled.
interface core_output_buf_multi_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int CTX_W     = 2,
    parameter int WORD_W    = 3
);
    logic [IN_WIDTH-1:0]     din;
    logic                    wr_en;
    logic [CTX_W+WORD_W-1:0] wr_addr;
    logic                    wr_seq;
    logic [OUT_WIDTH-1:0]    dout;
    logic                    dout_valid;
    logic                    core_out_ready;
    logic                    core_out_start;
    logic [CTX_W-1:0]        core_out_ctx_num;
    logic                    core_out_seq_num;
    logic                    rd_en;

    // Environment side: writer and consumer.
    modport master (
        output din, wr_en, wr_addr, wr_seq, rd_en,
        input  dout, dout_valid, core_out_ready, core_out_start,
               core_out_ctx_num, core_out_seq_num
    );

    // Buffer side.
    modport slave (
        input  din, wr_en, wr_addr, wr_seq, rd_en,
        output dout, dout_valid, core_out_ready, core_out_start,
               core_out_ctx_num, core_out_seq_num
    );
endinterface

// File: rtl/core_output_buf_multi_rr_select.sv
// Round-robin picker: returns the first requesting index after ptr, wrapping.
module core_output_buf_multi_rr_select
    import core_output_buf_multi_pkg::*;
#(
    parameter int N = 4,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] grant_idx_o,
    output logic         any_o
);
    logic [W-1:0] idx;

    // Scan from farthest to nearest so the nearest request after ptr wins.
    always_comb begin
        grant_idx_o = '0;
        any_o       = 1'b0;
        idx         = '0;
        for (int i = N; i >= 1; i--) begin
            idx = ptr_i + W'(i);
            if (req_i[idx]) begin
                grant_idx_o = idx;
                any_o       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/core_output_buf_multi.sv
// Multi-slot output buffer: stores N_CTX results in block RAM and streams them
// as OUT_WIDTH beats (low slice first), servicing full slots round-robin.
// Optional feature macro: CORE_OUTPUT_BUF_ERR_CNT_EN adds the err_cnt port.
module core_output_buf_multi
    import core_output_buf_multi_pkg::*;
#(
    parameter int N_CTX     = CORE_OUT_N_CTX,
    parameter int N_WORDS   = CORE_OUT_N_WORDS,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   rst,
    core_output_buf_multi_if.slave bus,
    output out_state_t             dbg_state_o,
    output logic [N_CTX-1:0]       dbg_full_o
`ifdef CORE_OUTPUT_BUF_ERR_CNT_EN
    ,
    output logic [15:0]            err_cnt
`endif
);
    localparam int CTX_W  = clog2(N_CTX);
    localparam int WORD_W = clog2(N_WORDS);
    localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int SEL_W  = clog2(RATIO);
    localparam int SLC_W  = (SEL_W == 0) ? 1 : SEL_W;
    localparam int CNT_W  = WORD_W + SEL_W;
    localparam int DEPTH  = N_CTX * N_WORDS;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_WORDS * RATIO - 1);

    out_state_t        state_q, state_d;
    logic [N_CTX-1:0]  full_q, full_d, seq_q, seq_d;
    logic [CTX_W-1:0]  rr_ptr_q, rr_ptr_d, ctx_q, ctx_d, grant_idx;
    logic              seq_num_q, seq_num_d, ready_q, ready_d;
    logic              rearm_q, rearm_d, grant_any;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [CTX_W-1:0]  wr_slot;
    logic [WORD_W-1:0] wr_word, rd_word;
    logic              wr_head;
    logic [SLC_W-1:0]  rd_slice, slice_q;
    logic              valid_q, start_q;
    logic [IN_WIDTH-1:0] ram_q;
    (* ram_style = "block" *) logic [IN_WIDTH-1:0] mem [DEPTH];

    assign wr_slot  = bus.wr_addr[CTX_W+WORD_W-1:WORD_W];
    assign wr_word  = bus.wr_addr[WORD_W-1:0];
    // The writer fills words high..low, so word 0 completes a result.
    assign wr_head  = bus.wr_en && (wr_word == '0);
    assign rd_word  = WORD_W'(beat_q / CNT_W'(RATIO));
    assign rd_slice = SLC_W'(beat_q % CNT_W'(RATIO));

    core_output_buf_multi_rr_select #(.N(N_CTX)) u_rr (
        .req_i       (full_q),
        .ptr_i       (rr_ptr_q),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    // FSM and slot bookkeeping registers.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= ST_NONE;
            full_q    <= '0;
            seq_q     <= '0;
            rr_ptr_q  <= CTX_W'(N_CTX - 1);
            ctx_q     <= '0;
            seq_num_q <= 1'b0;
            ready_q   <= 1'b0;
            beat_q    <= '0;
            rearm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            seq_q     <= seq_d;
            rr_ptr_q  <= rr_ptr_d;
            ctx_q     <= ctx_d;
            seq_num_q <= seq_num_d;
            ready_q   <= ready_d;
            beat_q    <= beat_d;
            rearm_q   <= rearm_d;
        end
    end

    // Next state: arbitration, offer, beat counting; a write to word 0 is
    // applied last so a set beats a clear on the same slot. A slot rewritten
    // while it streams stays full (rearm) so the new result is offered again.
    always_comb begin
        state_d   = state_q;
        full_d    = full_q;
        seq_d     = seq_q;
        rr_ptr_d  = rr_ptr_q;
        ctx_d     = ctx_q;
        seq_num_d = seq_num_q;
        ready_d   = ready_q;
        beat_d    = beat_q;
        rearm_d   = rearm_q;
        case (state_q)
            ST_NONE: begin
                rearm_d = 1'b0;
                if (grant_any) begin
                    ctx_d     = grant_idx;
                    seq_num_d = seq_q[grant_idx];
                    rr_ptr_d  = grant_idx;
                    ready_d   = 1'b1;
                    state_d   = ST_READY;
                end
            end
            ST_READY: begin
                if (bus.rd_en) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                ready_d = 1'b0;
                beat_d  = '0;
                state_d = ST_READ;
            end
            ST_READ: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    beat_d = '0;
                    if (!rearm_q) begin
                        full_d[ctx_q] = 1'b0;
                    end
                    state_d = ST_NONE;
                end
            end
            default: state_d = ST_NONE;
        endcase
        if (wr_head) begin
            full_d[wr_slot] = 1'b1;
            seq_d[wr_slot]  = bus.wr_seq;
            if ((state_q == ST_START || state_q == ST_READ) && wr_slot == ctx_q) begin
                rearm_d = 1'b1;
            end
        end
    end

    // Result RAM: write port from core, registered read port for streaming.
    always_ff @(posedge CLK) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.din;
        end
        ram_q <= mem[{ctx_q, rd_word}];
    end

    // Output qualifiers aligned with the registered RAM read.
    always_ff @(posedge CLK) begin
        if (rst) begin
            valid_q <= 1'b0;
            start_q <= 1'b0;
            slice_q <= '0;
        end else begin
            valid_q <= (state_q == ST_READ);
            start_q <= (state_q == ST_READ) && (beat_q == '0);
            slice_q <= rd_slice;
        end
    end

    assign bus.dout             = valid_q ? ram_q[int'(slice_q) * OUT_WIDTH +: OUT_WIDTH] : '0;
    assign bus.dout_valid       = valid_q;
    assign bus.core_out_start   = start_q;
    assign bus.core_out_ready   = ready_q;
    assign bus.core_out_ctx_num = ctx_q;
    assign bus.core_out_seq_num = seq_num_q;
    assign dbg_state_o          = state_q;
    assign dbg_full_o           = full_q;

`ifdef CORE_OUTPUT_BUF_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Count completions landing on a slot that is still full; saturating.
    always_ff @(posedge CLK) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (wr_head && full_q[wr_slot] && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_core_output_buf_multi.sv
// Directed bench for core_output_buf_multi: default build plus an 8x4x64/16 instance.
module tb_core_output_buf_multi;
    import core_output_buf_multi_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_output_buf_multi_if #(.IN_WIDTH(32), .OUT_WIDTH(16), .CTX_W(2), .WORD_W(3)) bus ();
    core_output_buf_multi_if #(.IN_WIDTH(64), .OUT_WIDTH(16), .CTX_W(3), .WORD_W(2)) bus5 ();

    out_state_t  dbg_state, dbg_state5;
    logic [3:0]  dbg_full;
    logic [7:0]  dbg_full5;
`ifdef CORE_OUTPUT_BUF_ERR_CNT_EN
    logic [15:0] err_cnt, err_cnt5;
`endif

    core_output_buf_multi #(.N_CTX(4), .N_WORDS(8), .IN_WIDTH(32), .OUT_WIDTH(16)) u_dut (
        .CLK         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state),
        .dbg_full_o  (dbg_full)
`ifdef CORE_OUTPUT_BUF_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    core_output_buf_multi #(.N_CTX(8), .N_WORDS(4), .IN_WIDTH(64), .OUT_WIDTH(16)) u_dut5 (
        .CLK         (clk),
        .rst         (rst),
        .bus         (bus5),
        .dbg_state_o (dbg_state5),
        .dbg_full_o  (dbg_full5)
`ifdef CORE_OUTPUT_BUF_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt5)
`endif
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [31:0] mem_m [4][8];
    logic [3:0]  full_m = '0;
    logic [3:0]  seq_m  = '0;
    int          err_m  = 0;
    bit          streaming_m = 1'b0;
    bit          rearm_m     = 1'b0;
    int          cur_ctx_m   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int word, input int salt);
        return {8'(word), 8'(word), 8'(salt), 8'hAA};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic write_word(input int slot, input int word, input logic [31:0] data, input logic seq);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'(slot * 8 + word);
        bus.din     = data;
        bus.wr_seq  = seq;
        mem_m[slot][word] = data;
        if (word == 0) begin
            if (full_m[slot]) err_m++;
            full_m[slot] = 1'b1;
            seq_m[slot]  = seq;
            if (streaming_m && slot == cur_ctx_m) rearm_m = 1'b1;
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic write_slot(input int slot, input logic seq, input int salt);
        for (int w = 7; w >= 0; w--) write_word(slot, w, pat(w, salt), seq);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (bus.core_out_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Accept one offer and compare the full beat stream against the model.
    task automatic serve(input int exp_ctx, input logic exp_seq, input string tag);
        bit ok;
        logic [15:0] e;
        wait_ready(ok);
        check({tag, "_ready_timeout"}, 64'(ok), 64'(1));
        if (!ok) return;
        check({tag, "_ctx"}, 64'(bus.core_out_ctx_num), 64'(exp_ctx));
        check({tag, "_seq"}, 64'(bus.core_out_seq_num), 64'(exp_seq));
        for (int w = 0; w < 8; w++) begin
            exp_q.push_back(mem_m[exp_ctx][w][15:0]);
            exp_q.push_back(mem_m[exp_ctx][w][31:16]);
        end
        bus.rd_en   = 1'b1;
        cur_ctx_m   = exp_ctx;
        streaming_m = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        check({tag, "_ready_t1"}, 64'(bus.core_out_ready), 64'(1));
        check({tag, "_valid_t1"}, 64'(bus.dout_valid), 64'(0));
        @(negedge clk);
        check({tag, "_ready_t2"}, 64'(bus.core_out_ready), 64'(0));
        check({tag, "_valid_t2"}, 64'(bus.dout_valid), 64'(0));
        for (int b = 0; b < 16; b++) begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
            check($sformatf("%s_valid_b%0d", tag, b), 64'(bus.dout_valid), 64'(1));
            check($sformatf("%s_start_b%0d", tag, b), 64'(bus.core_out_start), 64'(b == 0));
            check($sformatf("%s_dout_b%0d", tag, b), 64'(bus.dout), 64'(e));
        end
        @(negedge clk);
        check({tag, "_valid_end"}, 64'(bus.dout_valid), 64'(0));
        streaming_m = 1'b0;
        if (!rearm_m) full_m[exp_ctx] = 1'b0;
        rearm_m = 1'b0;
        check({tag, "_full_end"}, 64'(dbg_full), 64'(full_m));
    endtask

    // ---------------- table for the round-robin sequence ----------------
    // is_fill=1: write slot with seq/salt; is_fill=0: expect an offer of slot with seq.
    typedef struct {
        bit   is_fill;
        int   slot;
        logic seq;
        int   salt;
    } step_t;
    step_t steps[8];

    initial begin
        #300000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit seen;
        int beats;
        int starts;
        logic [15:0] e;

        bus.din = '0;  bus.wr_en = 1'b0;  bus.wr_addr = '0;  bus.wr_seq = 1'b0;  bus.rd_en = 1'b0;
        bus5.din = '0; bus5.wr_en = 1'b0; bus5.wr_addr = '0; bus5.wr_seq = 1'b0; bus5.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_ready", 64'(bus.core_out_ready), 64'(0));
        check("rst_valid", 64'(bus.dout_valid), 64'(0));
        check("rst_start", 64'(bus.core_out_start), 64'(0));
        check("rst_ctx", 64'(bus.core_out_ctx_num), 64'(0));
        check("rst_seq", 64'(bus.core_out_seq_num), 64'(0));
        check("rst_dout", 64'(bus.dout), 64'(0));
        check("rst_full", 64'(dbg_full), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(ST_NONE));
`ifdef CORE_OUTPUT_BUF_ERR_CNT_EN
        check("rst_err", 64'(err_cnt), 64'(0));
`endif

        // Test 1: slot 2, pattern {w,w,00,AA}, seq 1.
        write_slot(2, 1'b1, 0);
        check("t1_full_set", 64'(dbg_full), 64'(4'b0100));
        serve(2, 1'b1, "t1");

        // Test 2: round-robin order 0,1 then 3,0 after refilling slot 0.
        steps[0] = '{1'b1, 0, 1'b0, 1};
        steps[1] = '{1'b1, 1, 1'b1, 2};
        steps[2] = '{1'b1, 3, 1'b0, 3};
        steps[3] = '{1'b0, 0, 1'b0, 0};
        steps[4] = '{1'b0, 1, 1'b1, 0};
        steps[5] = '{1'b1, 0, 1'b1, 4};
        steps[6] = '{1'b0, 3, 1'b0, 0};
        steps[7] = '{1'b0, 0, 1'b1, 0};
        for (int i = 0; i < 8; i++) begin
            if (steps[i].is_fill) write_slot(steps[i].slot, steps[i].seq, steps[i].salt);
            else serve(steps[i].slot, steps[i].seq, $sformatf("t2_s%0d", i));
        end

        // Test 3: rewrite word 0 of slot 1 while it streams.
        write_slot(1, 1'b1, 5);
        fork
            serve(1, 1'b1, "t3a");
            begin
                for (int n = 0; n < 100 && !bus.dout_valid; n++) @(negedge clk);
                repeat (4) @(negedge clk);
                write_word(1, 0, 32'h5A5A_1234, 1'b0);
            end
        join
        check("t3_full_kept", 64'(dbg_full[1]), 64'(1));
`ifdef CORE_OUTPUT_BUF_ERR_CNT_EN
        check("t3_err", 64'(err_cnt), 64'(err_m));
`endif
        serve(1, 1'b0, "t3b");

        // Test 4: reset at beat 5 aborts the transfer and drops all slots.
        write_slot(2, 1'b0, 6);
        write_slot(3, 1'b1, 7);
        wait_ready(ok);
        check("t4_ready_timeout", 64'(ok), 64'(1));
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        for (int n = 0; n < 100 && !bus.dout_valid; n++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("t4_valid_before_rst", 64'(bus.dout_valid), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        full_m = '0; err_m = 0; exp_q.delete(); streaming_m = 1'b0; rearm_m = 1'b0;
        check("t4_ready", 64'(bus.core_out_ready), 64'(0));
        check("t4_valid", 64'(bus.dout_valid), 64'(0));
        check("t4_full", 64'(dbg_full), 64'(0));
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.core_out_ready || bus.dout_valid) seen = 1'b1;
        end
        check("t4_no_offer", 64'(seen), 64'(0));
`ifdef CORE_OUTPUT_BUF_ERR_CNT_EN
        check("t4_err", 64'(err_cnt), 64'(0));
`endif
        write_slot(3, 1'b1, 8);
        serve(3, 1'b1, "t4b");

        // Test 6: rd_en held high in NONE and through the transfer.
        bus.rd_en = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_idle_ready", 64'(bus.core_out_ready), 64'(0));
        check("t6_idle_valid", 64'(bus.dout_valid), 64'(0));
        write_slot(1, 1'b0, 9);
        for (int w = 0; w < 8; w++) begin
            exp_q.push_back(mem_m[1][w][15:0]);
            exp_q.push_back(mem_m[1][w][31:16]);
        end
        beats = 0;
        starts = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.core_out_start) starts++;
            if (bus.dout_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
                check($sformatf("t6_dout_b%0d", beats), 64'(bus.dout), 64'(e));
                beats++;
            end
        end
        bus.rd_en = 1'b0;
        full_m[1] = 1'b0;
        check("t6_beats", 64'(beats), 64'(16));
        check("t6_starts", 64'(starts), 64'(1));
        check("t6_ready_after", 64'(bus.core_out_ready), 64'(0));
        check("t6_full", 64'(dbg_full), 64'(full_m));

        // Test 5: 8 slots, 4 words of 64 bits, 16-bit beats, slot 7.
        for (int w = 3; w >= 0; w--) begin
            @(negedge clk);
            bus5.wr_en   = 1'b1;
            bus5.wr_addr = 5'(7 * 4 + w);
            bus5.din     = {16'(16'h7003 + w * 16), 16'(16'h7002 + w * 16),
                            16'(16'h7001 + w * 16), 16'(16'h7000 + w * 16)};
            bus5.wr_seq  = 1'b1;
            @(negedge clk);
            bus5.wr_en = 1'b0;
        end
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (bus5.core_out_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t5_ready_timeout", 64'(ok), 64'(1));
        check("t5_ctx", 64'(bus5.core_out_ctx_num), 64'(7));
        check("t5_seq", 64'(bus5.core_out_seq_num), 64'(1));
        bus5.rd_en = 1'b1;
        @(negedge clk);
        bus5.rd_en = 1'b0;
        for (int n = 0; n < 100 && !bus5.dout_valid; n++) @(negedge clk);
        for (int b = 0; b < 16; b++) begin
            check($sformatf("t5_valid_b%0d", b), 64'(bus5.dout_valid), 64'(1));
            check($sformatf("t5_start_b%0d", b), 64'(bus5.core_out_start), 64'(b == 0));
            check($sformatf("t5_dout_b%0d", b), 64'(bus5.dout), 64'(16'h7000 + (b / 4) * 16 + (b % 4)));
            @(negedge clk);
        end
        check("t5_valid_end", 64'(bus5.dout_valid), 64'(0));
        check("t5_full_end", 64'(dbg_full5), 64'(0));

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
